// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, operand-source fields,
// forwarding selects and the mul/div FSM state.
package ex_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ALUCTRL_W  = 5;
    localparam int unsigned ALUSRC_W   = 5;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned IMM_W      = 16;
    localparam int unsigned MD_CNT_W   = 5;

    typedef enum logic [ALUCTRL_W-1:0] {
        ALU_ADD   = 5'd0,
        ALU_ADDU  = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SUBU  = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_NOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SLL   = 5'd10,
        ALU_SRL   = 5'd11,
        ALU_SRA   = 5'd12,
        ALU_LUI   = 5'd13,
        ALU_LINK  = 5'd14,
        ALU_MFHI  = 5'd15,
        ALU_MFLO  = 5'd16,
        ALU_MTHI  = 5'd17,
        ALU_MTLO  = 5'd18,
        ALU_MULT  = 5'd19,
        ALU_MULTU = 5'd20,
        ALU_DIV   = 5'd21,
        ALU_DIVU  = 5'd22
    } alu_ctrl_e;

    // ALUSrc field layout
    localparam int unsigned ALUSRC_B_LSB     = 0;
    localparam int unsigned ALUSRC_SHAMT_BIT = 2;

    localparam logic [1:0] BSRC_REG  = 2'b00;
    localparam logic [1:0] BSRC_SEXT = 2'b01;
    localparam logic [1:0] BSRC_ZEXT = 2'b10;
    localparam logic [1:0] BSRC_LUI  = 2'b11;

    localparam logic [1:0] FWD_IDEX = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    // bit 1 = divide, bit 0 = unsigned
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative 32-step multiply/divide: shift-add multiply, restoring divide,
// both on magnitudes with sign fixup applied to the final step.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  md_op_e            op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W:0]       acc_q, acc_d;
    logic [DATA_W-1:0]     q_q, q_d;
    logic [DATA_W-1:0]     m_q, m_d;
    logic                  div_q, div_d;
    logic                  negp_q, negp_d;
    logic                  negr_q, negr_d;
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;

    logic                  sgn;
    logic [DATA_W:0]       mul_sum;
    logic [DATA_W:0]       div_r;
    logic [DATA_W+1:0]     div_diff;
    logic [DATA_W:0]       step_acc;
    logic [DATA_W-1:0]     step_q;
    logic [2*DATA_W-1:0]   prod;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            m_q     <= m_d;
            div_q   <= div_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        div_d   = div_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn     = ~op[0];

        // one iteration; the final one also feeds the result fixup
        mul_sum  = acc_q + (q_q[0] ? {1'b0, m_q} : (DATA_W+1)'(0));
        div_r    = {acc_q[DATA_W-1:0], q_q[DATA_W-1]};
        div_diff = {1'b0, div_r} - {2'b00, m_q};
        if (div_q) begin
            step_acc = div_diff[DATA_W+1] ? div_r : div_diff[DATA_W:0];
            step_q   = {q_q[DATA_W-2:0], ~div_diff[DATA_W+1]};
        end else begin
            step_acc = {1'b0, mul_sum[DATA_W:1]};
            step_q   = {mul_sum[0], q_q[DATA_W-1:1]};
        end

        prod = {step_acc[DATA_W-1:0], step_q};
        if (negp_q) prod = (2*DATA_W)'(-prod);
        quo  = negp_q ? DATA_W'(-step_q) : step_q;
        rem  = negr_q ? DATA_W'(-step_acc[DATA_W-1:0]) : step_acc[DATA_W-1:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    q_d     = (sgn && a[DATA_W-1]) ? DATA_W'(-a) : a;
                    m_d     = (sgn && b[DATA_W-1]) ? DATA_W'(-b) : b;
                    div_d   = op[1];
                    // divide-by-zero keeps the all-ones quotient unsigned
                    negp_d  = sgn && (a[DATA_W-1] ^ b[DATA_W-1]) && !(op[1] && (b == '0));
                    negr_d  = sgn && op[1] && a[DATA_W-1];
                end
            end
            BUSY: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(31)) begin
                    state_d = DONE;
                    hi_d    = div_q ? rem : prod[2*DATA_W-1:DATA_W];
                    lo_d    = div_q ? quo : prod[DATA_W-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, ALU, HI/LO registers and mul/div stall.
module ex_stage
    import ex_pkg::*;
(
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 Valid_In,
    input  logic [ALUCTRL_W-1:0] ALUCtrl_In,
    input  logic [ALUSRC_W-1:0]  ALUSrc_In,
    input  logic [DATA_W-1:0]    RegData1_In,
    input  logic [DATA_W-1:0]    RegData2_In,
    input  logic [1:0]           FwdA_SEL,
    input  logic [1:0]           FwdB_SEL,
    input  logic [DATA_W-1:0]    FwdMem_In,
    input  logic [DATA_W-1:0]    FwdWb_In,
    input  logic [SHAMT_W-1:0]   Shamt_In,
    input  logic [IMM_W-1:0]     Imm_In,
    input  logic [DATA_W-1:0]    PCAddr_In,
    output logic [DATA_W-1:0]    ALUResult_Out,
    output logic [DATA_W-1:0]    StoreData_Out,
    output logic                 Overflow_Out,
    output logic                 Stall_Out,
    output logic [DATA_W-1:0]    HI_Out,
    output logic [DATA_W-1:0]    LO_Out
);

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b_reg;
    logic [DATA_W-1:0]  op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  add_res;
    logic [DATA_W-1:0]  sub_res;
    logic               ovf_add;
    logic               ovf_sub;
    logic [DATA_W-1:0]  hi_q;
    logic [DATA_W-1:0]  lo_q;
    logic               md_req;
    md_op_e             md_op;
    logic               md_start;
    logic               md_busy;
    logic               md_done;
    logic [DATA_W-1:0]  md_hi;
    logic [DATA_W-1:0]  md_lo;
    logic               hi_we;
    logic               lo_we;
    logic [1:0]         unused_src;

    assign unused_src = ALUSrc_In[4:3];

    // reserved forwarding code 11 falls back to the ID/EX value
    always_comb begin
        op_a = RegData1_In;
        case (FwdA_SEL)
            FWD_MEM: op_a = FwdMem_In;
            FWD_WB:  op_a = FwdWb_In;
            default: op_a = RegData1_In;
        endcase
        op_b_reg = RegData2_In;
        case (FwdB_SEL)
            FWD_MEM: op_b_reg = FwdMem_In;
            FWD_WB:  op_b_reg = FwdWb_In;
            default: op_b_reg = RegData2_In;
        endcase
        op_b = op_b_reg;
        case (ALUSrc_In[ALUSRC_B_LSB +: 2])
            BSRC_SEXT: op_b = {{(DATA_W-IMM_W){Imm_In[IMM_W-1]}}, Imm_In};
            BSRC_ZEXT: op_b = {{(DATA_W-IMM_W){1'b0}}, Imm_In};
            BSRC_LUI:  op_b = {Imm_In, {(DATA_W-IMM_W){1'b0}}};
            default:   op_b = op_b_reg;
        endcase
    end

    assign shamt         = ALUSrc_In[ALUSRC_SHAMT_BIT] ? op_a[SHAMT_W-1:0] : Shamt_In;
    assign StoreData_Out = op_b_reg;
    assign add_res       = op_a + op_b;
    assign sub_res       = op_a - op_b;
    assign ovf_add       = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (add_res[DATA_W-1] != op_a[DATA_W-1]);
    assign ovf_sub       = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (sub_res[DATA_W-1] != op_a[DATA_W-1]);
    assign Overflow_Out  = Valid_In && (((ALUCtrl_In == ALU_ADD) && ovf_add) ||
                                        ((ALUCtrl_In == ALU_SUB) && ovf_sub));

    always_comb begin
        ALUResult_Out = '0;
        case (ALUCtrl_In)
            ALU_ADD, ALU_ADDU: ALUResult_Out = add_res;
            ALU_SUB, ALU_SUBU: ALUResult_Out = sub_res;
            ALU_AND:  ALUResult_Out = op_a & op_b;
            ALU_OR:   ALUResult_Out = op_a | op_b;
            ALU_XOR:  ALUResult_Out = op_a ^ op_b;
            ALU_NOR:  ALUResult_Out = ~(op_a | op_b);
            ALU_SLT:  ALUResult_Out = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: ALUResult_Out = {{(DATA_W-1){1'b0}}, op_a < op_b};
            ALU_SLL:  ALUResult_Out = op_b << shamt;
            ALU_SRL:  ALUResult_Out = op_b >> shamt;
            ALU_SRA:  ALUResult_Out = DATA_W'($signed(op_b) >>> shamt);
            ALU_LUI:  ALUResult_Out = op_b;
            ALU_LINK: ALUResult_Out = PCAddr_In + DATA_W'(8);
            ALU_MFHI: ALUResult_Out = HI_Out;
            ALU_MFLO: ALUResult_Out = LO_Out;
            default:  ALUResult_Out = '0;
        endcase
    end

    always_comb begin
        md_req = 1'b0;
        md_op  = MD_MULT;
        case (ALUCtrl_In)
            ALU_MULT:  begin md_req = 1'b1; md_op = MD_MULT;  end
            ALU_MULTU: begin md_req = 1'b1; md_op = MD_MULTU; end
            ALU_DIV:   begin md_req = 1'b1; md_op = MD_DIV;   end
            ALU_DIVU:  begin md_req = 1'b1; md_op = MD_DIVU;  end
            default:   begin md_req = 1'b0; md_op = MD_MULT;  end
        endcase
    end

    // DONE still holds the issuing instruction in ID/EX, so it must not restart
    assign md_start  = Valid_In && md_req && !md_busy && !md_done;
    assign Stall_Out = md_start || md_busy;
    assign hi_we     = Valid_In && !Stall_Out && (ALUCtrl_In == ALU_MTHI);
    assign lo_we     = Valid_In && !Stall_Out && (ALUCtrl_In == ALU_MTLO);

    muldiv_unit u_muldiv (
        .clk   (CLOCK),
        .rst_n (RESET),
        .start (md_start),
        .op    (md_op),
        .a     (op_a),
        .b     (op_b),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // the unit's result is shown during DONE and committed at its end
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_done) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
        end else begin
            if (hi_we) hi_q <= op_a;
            if (lo_we) lo_q <= op_a;
        end
    end

    assign HI_Out = md_done ? md_hi : hi_q;
    assign LO_Out = md_done ? md_lo : lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vector table plus HI/LO and mul/div sequences.
module tb_ex_stage;
    import ex_pkg::*;

    logic        CLOCK;
    logic        RESET;
    logic        Valid_In;
    logic [4:0]  ALUCtrl_In;
    logic [4:0]  ALUSrc_In;
    logic [31:0] RegData1_In, RegData2_In;
    logic [1:0]  FwdA_SEL, FwdB_SEL;
    logic [31:0] FwdMem_In, FwdWb_In;
    logic [4:0]  Shamt_In;
    logic [15:0] Imm_In;
    logic [31:0] PCAddr_In;
    logic [31:0] ALUResult_Out, StoreData_Out, HI_Out, LO_Out;
    logic        Overflow_Out, Stall_Out;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .Valid_In     (Valid_In),
        .ALUCtrl_In   (ALUCtrl_In),
        .ALUSrc_In    (ALUSrc_In),
        .RegData1_In  (RegData1_In),
        .RegData2_In  (RegData2_In),
        .FwdA_SEL     (FwdA_SEL),
        .FwdB_SEL     (FwdB_SEL),
        .FwdMem_In    (FwdMem_In),
        .FwdWb_In     (FwdWb_In),
        .Shamt_In     (Shamt_In),
        .Imm_In       (Imm_In),
        .PCAddr_In    (PCAddr_In),
        .ALUResult_Out(ALUResult_Out),
        .StoreData_Out(StoreData_Out),
        .Overflow_Out (Overflow_Out),
        .Stall_Out    (Stall_Out),
        .HI_Out       (HI_Out),
        .LO_Out       (LO_Out)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        string       name;
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  src;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] fmem;
        logic [31:0] fwb;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] exp_res;
        logic [31:0] exp_st;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [4:0] op,
                         input logic [31:0] r1, input logic [31:0] r2);
        Valid_In    = valid;
        ALUCtrl_In  = op;
        ALUSrc_In   = 5'd0;
        RegData1_In = r1;
        RegData2_In = r2;
        FwdA_SEL    = 2'b00;
        FwdB_SEL    = 2'b00;
        FwdMem_In   = 32'h0;
        FwdWb_In    = 32'h0;
        Shamt_In    = 5'd0;
        Imm_In      = 16'h0;
        PCAddr_In   = 32'h0;
    endtask

    // Issue a mul/div, count stall cycles, check DONE values and optionally MFLO/MFHI.
    task automatic run_muldiv(input string name, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input bit follow_mf, input bit scramble);
        int n;
        @(posedge CLOCK); #1;
        drive(1'b1, op, a, b);
        n = 0;
        @(negedge CLOCK);
        while (Stall_Out === 1'b1 && n < 100) begin
            n++;
            if (scramble && n == 5) begin
                Valid_In    = 1'b0;
                ALUCtrl_In  = ALU_ADD;
                RegData1_In = 32'h5A5A5A5A;
                RegData2_In = 32'h0;
                FwdA_SEL    = 2'b01;
                FwdMem_In   = 32'h12345678;
            end
            @(negedge CLOCK);
        end
        check({name, "_stall_cycles"}, 32'(n), 32'd33);
        check({name, "_done_hi"}, HI_Out, exp_hi);
        check({name, "_done_lo"}, LO_Out, exp_lo);
        if (follow_mf) begin
            @(posedge CLOCK); #1;
            drive(1'b1, ALU_MFLO, 32'h0, 32'h0);
            @(negedge CLOCK);
            check({name, "_mflo"}, ALUResult_Out, exp_lo);
            check({name, "_no_reissue"}, {31'd0, Stall_Out}, 32'd0);
            @(posedge CLOCK); #1;
            drive(1'b1, ALU_MFHI, 32'h0, 32'h0);
            @(negedge CLOCK);
            check({name, "_mfhi"}, ALUResult_Out, exp_hi);
        end
    endtask

    initial begin
        vecs[0]  = '{"add_fwd_mem", 1, ALU_ADD,  5'b00000, 32'h0, 32'h7, 2'b01, 2'b00, 32'h5, 32'h0, 5'd0, 16'h0, 32'h0, 32'hC, 32'h7, 0};
        vecs[1]  = '{"add_ovf", 1, ALU_ADD, 5'b00000, 32'h7FFFFFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'h1, 1};
        vecs[2]  = '{"addu_noovf", 1, ALU_ADDU, 5'b00000, 32'h7FFFFFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'h1, 0};
        vecs[3]  = '{"add_ovf_bubble", 0, ALU_ADD, 5'b00000, 32'h7FFFFFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'h1, 0};
        vecs[4]  = '{"sub_ovf", 1, ALU_SUB, 5'b00000, 32'h80000000, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h7FFFFFFF, 32'h1, 1};
        vecs[5]  = '{"sub_ovf_neg", 1, ALU_SUB, 5'b00000, 32'h0, 32'h80000000, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h80000000, 32'h80000000, 1};
        vecs[6]  = '{"subu", 1, ALU_SUBU, 5'b00000, 32'h3, 32'h5, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'hFFFFFFFE, 32'h5, 0};
        vecs[7]  = '{"and_zext", 1, ALU_AND, 5'b00010, 32'hF0F0F0F0, 32'h12345678, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'hFFFF, 32'h0, 32'h0000F0F0, 32'h12345678, 0};
        vecs[8]  = '{"or_sext", 1, ALU_OR, 5'b00001, 32'h1, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h8000, 32'h0, 32'hFFFF8001, 32'h0, 0};
        vecs[9]  = '{"xor_fwd_wb", 1, ALU_XOR, 5'b00000, 32'hFFFF0000, 32'h0, 2'b00, 2'b10, 32'h0, 32'h0F0F0F0F, 5'd0, 16'h0, 32'h0, 32'hF0F00F0F, 32'h0F0F0F0F, 0};
        vecs[10] = '{"nor", 1, ALU_NOR, 5'b00000, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'hFFFFFFFF, 32'h0, 0};
        vecs[11] = '{"slt", 1, ALU_SLT, 5'b00000, 32'hFFFFFFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h1, 32'h1, 0};
        vecs[12] = '{"sltu", 1, ALU_SLTU, 5'b00000, 32'hFFFFFFFF, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h0, 32'h1, 0};
        vecs[13] = '{"sll31", 1, ALU_SLL, 5'b00000, 32'h0, 32'h1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd31, 16'h0, 32'h0, 32'h80000000, 32'h1, 0};
        vecs[14] = '{"srl_var", 1, ALU_SRL, 5'b00100, 32'h4, 32'h80000000, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h0, 32'h08000000, 32'h80000000, 0};
        vecs[15] = '{"sra", 1, ALU_SRA, 5'b00000, 32'h0, 32'h80000000, 2'b00, 2'b00, 32'h0, 32'h0, 5'd4, 16'h0, 32'h0, 32'hF8000000, 32'h80000000, 0};
        vecs[16] = '{"lui", 1, ALU_LUI, 5'b00011, 32'h0, 32'hAAAA5555, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h1234, 32'h0, 32'h12340000, 32'hAAAA5555, 0};
        vecs[17] = '{"link", 1, ALU_LINK, 5'b00000, 32'h0, 32'h0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0, 32'h00400000, 32'h00400008, 32'h0, 0};
        vecs[18] = '{"fwd_reserved", 1, ALU_ADD, 5'b00000, 32'h1, 32'h2, 2'b11, 2'b11, 32'h100, 32'h200, 5'd0, 16'h0, 32'h0, 32'h3, 32'h2, 0};
        vecs[19] = '{"fwd_wb_mem", 1, ALU_ADD, 5'b00000, 32'h1, 32'h2, 2'b10, 2'b01, 32'h14, 32'hA, 5'd0, 16'h0, 32'h0, 32'h1E, 32'h14, 0};

        RESET = 1'b0;
        drive(1'b0, ALU_ADD, 32'h0, 32'h0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        check("reset_hi", HI_Out, 32'h0);
        check("reset_lo", LO_Out, 32'h0);
        check("reset_stall", {31'd0, Stall_Out}, 32'd0);
        RESET = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge CLOCK); #1;
            Valid_In    = vecs[i].valid;
            ALUCtrl_In  = vecs[i].op;
            ALUSrc_In   = vecs[i].src;
            RegData1_In = vecs[i].r1;
            RegData2_In = vecs[i].r2;
            FwdA_SEL    = vecs[i].fa;
            FwdB_SEL    = vecs[i].fb;
            FwdMem_In   = vecs[i].fmem;
            FwdWb_In    = vecs[i].fwb;
            Shamt_In    = vecs[i].shamt;
            Imm_In      = vecs[i].imm;
            PCAddr_In   = vecs[i].pc;
            @(negedge CLOCK);
            check({vecs[i].name, "_res"}, ALUResult_Out, vecs[i].exp_res);
            check({vecs[i].name, "_store"}, StoreData_Out, vecs[i].exp_st);
            check({vecs[i].name, "_ovf"}, {31'd0, Overflow_Out}, {31'd0, vecs[i].exp_ovf});
        end

        // MTHI then MFHI
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MTHI, 32'hDEADBEEF, 32'h0);
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MFHI, 32'h0, 32'h0);
        @(negedge CLOCK);
        check("mthi_mfhi", ALUResult_Out, 32'hDEADBEEF);
        // bubble MTLO must not write
        @(posedge CLOCK); #1;
        drive(1'b0, ALU_MTLO, 32'h11111111, 32'h0);
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MFLO, 32'h0, 32'h0);
        @(negedge CLOCK);
        check("mtlo_bubble", ALUResult_Out, 32'h0);
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MTLO, 32'h13579BDF, 32'h0);
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MFLO, 32'h0, 32'h0);
        @(negedge CLOCK);
        check("mtlo_mflo", ALUResult_Out, 32'h13579BDF);

        run_muldiv("mult_neg",   ALU_MULT,  32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1, 0);
        run_muldiv("div_neg",    ALU_DIV,   32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run_muldiv("divu_zero",  ALU_DIVU,  32'h9, 32'h0, 32'h9, 32'hFFFFFFFF, 1, 1);
        run_muldiv("div_negb",   ALU_DIV,   32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1, 0);
        run_muldiv("multu_max",  ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 0);
        run_muldiv("mult_min",   ALU_MULT,  32'h80000000, 32'h2, 32'hFFFFFFFF, 32'h0, 1, 0);
        run_muldiv("div_zero_s", ALU_DIV,   32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 0);

        // reset at BUSY cycle 10 abandons the operation
        @(posedge CLOCK); #1;
        drive(1'b1, ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (11) @(posedge CLOCK);
        #1;
        check("pre_reset_stall", {31'd0, Stall_Out}, 32'd1);
        RESET    = 1'b0;
        Valid_In = 1'b0;
        #1;
        check("mid_reset_stall", {31'd0, Stall_Out}, 32'd0);
        check("mid_reset_hi", HI_Out, 32'h0);
        check("mid_reset_lo", LO_Out, 32'h0);
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        check("post_reset_hi", HI_Out, 32'h0);
        run_muldiv("multu_after_rst", ALU_MULTU, 32'h6, 32'h7, 32'h0, 32'd42, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
